// File: rtl/perceptron_layer_seq.sv
// Time-multiplexed fully-connected layer: M neurons share one P-lane MAC datapath,
// followed by shift/saturate quantisation and a selectable activation.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

module perceptron_layer_seq #(
    parameter int N          = 16,
    parameter int M          = 4,
    parameter int P          = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ACC_WIDTH  = `ACC_WIDTH,
    parameter int SHIFT      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N*DATA_WIDTH-1:0]        x,
    input  logic [M*N*DATA_WIDTH-1:0]      w,
    input  logic [M*DATA_WIDTH-1:0]        b,
    input  logic [1:0]                     act_mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [M*DATA_WIDTH-1:0]        y
);

    localparam int BEATS = N / P;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int MW    = (M > 1) ? $clog2(M) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);
    localparam logic [MW-1:0] M_LAST = MW'(M - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    generate
        if (N % P != 0) begin : g_bad_lanes
            $error("perceptron_layer_seq: N must be a multiple of P");
        end
        if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(N)) begin : g_bad_acc
            $error("perceptron_layer_seq: ACC_WIDTH too narrow for N products");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;

    state_t                          state_reg, state_next;
    logic [N*DATA_WIDTH-1:0]         x_reg;
    logic [M*N*DATA_WIDTH-1:0]       w_reg;
    logic [M*DATA_WIDTH-1:0]         b_reg;
    logic [1:0]                      mode_reg;
    logic signed [ACC_WIDTH-1:0]     acc_reg;
    logic [KW-1:0]                   k_reg;
    logic [MW-1:0]                   m_reg;
    logic [M*DATA_WIDTH-1:0]         y_reg;

    logic signed [ACC_WIDTH-1:0]     lane_prod [P];
    logic signed [ACC_WIDTH-1:0]     beat_sum;
    logic signed [DATA_WIDTH-1:0]    b_sel;
    logic signed [ACC_WIDTH:0]       sum_full;
    logic signed [ACC_WIDTH:0]       shifted;
    logic signed [DATA_WIDTH-1:0]    q;
    logic signed [DATA_WIDTH-1:0]    act_val;

    // One lane per parallel element of the current beat of the current neuron
    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0]   xe;
            logic signed [DATA_WIDTH-1:0]   we;
            logic signed [2*DATA_WIDTH-1:0] prod;
            assign xe   = x_reg[(int'(k_reg)*P + gi)*DATA_WIDTH +: DATA_WIDTH];
            assign we   = w_reg[(int'(m_reg)*N + int'(k_reg)*P + gi)*DATA_WIDTH +: DATA_WIDTH];
            assign prod = xe * we;
            assign lane_prod[gi] = ACC_WIDTH'(prod);
        end
    endgenerate

    always_comb begin
        beat_sum = '0;
        for (int j = 0; j < P; j++) begin
            beat_sum = beat_sum + lane_prod[j];
        end
    end

    // Bias add one bit wider than the accumulator so saturation sees the true sum
    always_comb begin
        b_sel    = b_reg[int'(m_reg)*DATA_WIDTH +: DATA_WIDTH];
        sum_full = {acc_reg[ACC_WIDTH-1], acc_reg} + (ACC_WIDTH+1)'(b_sel);
        shifted  = sum_full >>> SHIFT;
        if (shifted > SAT_MAX) begin
            q = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            q = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            q = shifted[DATA_WIDTH-1:0];
        end
        case (mode_reg)
            2'd0:    act_val = q;
            2'd2:    act_val = q[DATA_WIDTH-1] ? (q >>> 3) : q;
            default: act_val = q[DATA_WIDTH-1] ? '0 : q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_next = MAC;
            end
            MAC: begin
                if (k_reg == K_LAST) state_next = FIN;
            end
            FIN: begin
                state_next = (m_reg == M_LAST) ? DONE : MAC;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg    <= '0;
            w_reg    <= '0;
            b_reg    <= '0;
            mode_reg <= '0;
            acc_reg  <= '0;
            k_reg    <= '0;
            m_reg    <= '0;
            y_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        x_reg    <= x;
                        w_reg    <= w;
                        b_reg    <= b;
                        mode_reg <= act_mode;
                        acc_reg  <= '0;
                        k_reg    <= '0;
                        m_reg    <= '0;
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + beat_sum;
                    k_reg   <= (k_reg == K_LAST) ? '0 : k_reg + KW'(1);
                end
                FIN: begin
                    // Only this neuron's slice changes; earlier results stay visible
                    y_reg[int'(m_reg)*DATA_WIDTH +: DATA_WIDTH] <= act_val;
                    acc_reg <= '0;
                    m_reg   <= (m_reg == M_LAST) ? '0 : m_reg + MW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign y = y_reg;

endmodule

// File: tb/tb_perceptron_layer_seq.sv
// Directed-vector bench for perceptron_layer_seq with default parameters (DW=8, N=16, M=4, P=4).

module tb_perceptron_layer_seq;

    localparam int N  = 16;
    localparam int M  = 4;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic [1:0]           act_mode = 2'd0;
    logic [N*DW-1:0]      x = '0;
    logic [M*N*DW-1:0]    w = '0;
    logic [M*DW-1:0]      b = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic [M*DW-1:0]      y;

    int errors = 0;
    int checks = 0;

    perceptron_layer_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .b         (b),
        .act_mode  (act_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_job(input logic [7:0] xv, input logic [7:0] wv,
                           input logic [31:0] bv, input logic [1:0] mode);
        x        = {N{xv}};
        w        = {(M*N){wv}};
        b        = bv;
        act_mode = mode;
    endtask

    // Called just after an edge while idle; scrambles the ports after the accept edge
    task automatic start_job(input string tag);
        check_val({tag, "_in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = ~x;
        w        = ~w;
        b        = ~b;
        act_mode = act_mode + 2'd1;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_latency"}, lat, 20);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, "_valid_drop"}, out_valid, 1'b0);
        check_val({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    task automatic run_job(input string tag, input logic [7:0] xv, input logic [7:0] wv,
                           input logic [31:0] bv, input logic [1:0] mode, input logic [31:0] exp);
        set_job(xv, wv, bv, mode);
        start_job(tag);
        wait_done(tag);
        check_val({tag, "_y"}, y, exp);
        $display("job %s: x=%0d w=%0d b=%h mode=%0d y=%h", tag, $signed(xv), $signed(wv), bv, mode, y);
        handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rec[3];
        int nrec;

        // Reset state
        #1;
        check_val("rst_in_ready", in_ready, 1'b0);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_y", y, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("idle_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // 1: all ones, ReLU -> 16 per neuron
        run_job("ones_relu", 8'd1, 8'd1, 32'h0, 2'd1, 32'h10101010);
        // 2/3: saturation both ways, all three activations
        run_job("satA_id", 8'd127, 8'd127, 32'h0, 2'd0, 32'h7f7f7f7f);
        run_job("satB_id", 8'd127, 8'h80, 32'h0, 2'd0, 32'h80808080);
        run_job("satB_relu", 8'd127, 8'h80, 32'h0, 2'd1, 32'h00000000);
        run_job("satB_leaky", 8'd127, 8'h80, 32'h0, 2'd2, 32'hf0f0f0f0);
        // 4: bias only, b = {-5,5,0,127} for m = 0..3
        run_job("bias_id", 8'd0, 8'd9, 32'h7f0005fb, 2'd0, 32'h7f0005fb);
        run_job("bias_leaky", 8'd0, 8'd9, 32'h7f0005fb, 2'd2, 32'h7f0005ff);
        run_job("bias_relu", 8'd0, 8'd9, 32'h7f0005fb, 2'd1, 32'h7f000500);
        run_job("bias_mode3", 8'd0, 8'd9, 32'h7f0005fb, 2'd3, 32'h7f000500);

        // 5: backpressure with a competing job offered
        set_job(8'd1, 8'd1, 32'h0, 2'd1);
        start_job("bp");
        wait_done("bp");
        set_job(8'd127, 8'd127, 32'h0, 2'd0);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check_val("bp_hold_valid", out_valid, 1'b1);
            check_val("bp_hold_ready", in_ready, 1'b0);
            check_val("bp_hold_y", y, 32'h10101010);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("bp_release_valid", out_valid, 1'b0);
        check_val("bp_release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("bp_accepted", in_ready, 1'b0);
        wait_done("bp_new");
        check_val("bp_new_y", y, 32'h7f7f7f7f);
        $display("job bp_new: y=%h", y);
        handshake("bp_new");

        // 6a: reset mid-job
        set_job(8'd127, 8'h80, 32'h0, 2'd0);
        start_job("abort");
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("abort_out_valid", out_valid, 1'b0);
        check_val("abort_y", y, 32'h0);
        check_val("abort_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_job("after_rst", 8'd1, 8'd1, 32'h0, 2'd1, 32'h10101010);

        // 6b: throughput with both handshakes tied high
        set_job(8'd2, 8'd3, 32'h0, 2'd0);
        nrec      = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (in_ready && nrec < 3) begin
                rec[nrec] = c;
                nrec++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("thr_accepts", nrec, 3);
        if (nrec == 3) begin
            check_val("thr_gap1", rec[1] - rec[0], 22);
            check_val("thr_gap2", rec[2] - rec[1], 22);
        end
        // 16 products of 2*3 = 96 per neuron
        check_val("thr_y", y, 32'h60606060);
        $display("job throughput: accepts=%0d y=%h", nrec, y);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
